// File: rtl/register_pkg.sv
// Shared definitions for the universal register: 3-bit operation codes,
// also used by the datapath decoder.
package register_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_INC  = 3'b010,
      MODE_DEC  = 3'b011,
      MODE_SHL  = 3'b100,
      MODE_SHR  = 3'b101,
      MODE_ROL  = 3'b110,
      MODE_ROR  = 3'b111
   } mode_e;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/register_universal_if.sv
// Operation/result bundle of the universal register; master drives the
// operation, slave (the register) returns value and status.
interface register_universal_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic [2:0]       mode;
   logic [WIDTH-1:0] data_in;
   logic             serial_in;
   logic [WIDTH-1:0] data_out;
   logic             carry_out;
   logic             zero;

   modport master (
      output enable, mode, data_in, serial_in,
      input  data_out, carry_out, zero
   );

   modport slave (
      input  enable, mode, data_in, serial_in,
      output data_out, carry_out, zero
   );
endinterface

// File: rtl/register_universal_next.sv
// Combinational next-value/next-carry generator for the universal register.
// REGISTER_UNIVERSAL_SAT_EN makes INC/DEC stick at their limits instead of wrapping.
module register_universal_next
   import register_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] v,
   input  logic             carry,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] next_value,
   output logic             next_carry
);

   // One extra bit captures wrap-around; the top bit is the carry/borrow.
   logic [WIDTH:0] inc_full;
   logic [WIDTH:0] dec_full;

   assign inc_full = {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_full = {1'b0, v} - {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      next_value = v;
      next_carry = carry;
      case (mode)
         MODE_HOLD: begin
            next_value = v;
            next_carry = carry;
         end
         MODE_LOAD: begin
            next_value = data_in;
            next_carry = 1'b0;
         end
         MODE_INC: begin
`ifdef REGISTER_UNIVERSAL_SAT_EN
            next_value = inc_full[WIDTH] ? v : inc_full[WIDTH-1:0];
`else
            next_value = inc_full[WIDTH-1:0];
`endif
            next_carry = inc_full[WIDTH];
         end
         MODE_DEC: begin
`ifdef REGISTER_UNIVERSAL_SAT_EN
            next_value = dec_full[WIDTH] ? v : dec_full[WIDTH-1:0];
`else
            next_value = dec_full[WIDTH-1:0];
`endif
            next_carry = dec_full[WIDTH];
         end
         MODE_SHL: begin
            next_value = {v[WIDTH-2:0], serial_in};
            next_carry = v[WIDTH-1];
         end
         MODE_SHR: begin
            next_value = {serial_in, v[WIDTH-1:1]};
            next_carry = v[0];
         end
         MODE_ROL: begin
            next_value = {v[WIDTH-2:0], v[WIDTH-1]};
            next_carry = v[WIDTH-1];
         end
         MODE_ROR: begin
            next_value = {v[0], v[WIDTH-1:1]};
            next_carry = v[0];
         end
         default: begin
            next_value = v;
            next_carry = carry;
         end
      endcase
   end

endmodule

// File: rtl/register_universal.sv
// WIDTH-bit universal register: state, synchronous active-low reset, enable
// gating and zero flag. Saturating INC/DEC via REGISTER_UNIVERSAL_SAT_EN.
module register_universal
   import register_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 nreset,
   register_universal_if.slave  bus
);

   logic [WIDTH-1:0] value;
   logic             carry;
   logic [WIDTH-1:0] next_value;
   logic             next_carry;

   register_universal_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .v          (value),
      .carry      (carry),
      .mode       (bus.mode),
      .data_in    (bus.data_in),
      .serial_in  (bus.serial_in),
      .next_value (next_value),
      .next_carry (next_carry)
   );

   // Reset outranks enable; with enable low the generator output is never used,
   // so X on mode/data_in/serial_in cannot leak into the state.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         value <= '0;
         carry <= 1'b0;
      end else if (bus.enable) begin
         value <= next_value;
         carry <= next_carry;
      end
   end

   assign bus.data_out  = value;
   assign bus.carry_out = carry;
   assign bus.zero      = (value == '0);

endmodule
